// File: rtl/irq_priority_ctrl8.sv
// irq_priority_ctrl8
// 8-source interrupt controller with 74LS148-style priority resolution.
// The request lines are active low, and bit 7 has the highest priority.
// Each request is synchronised. Its falling edge is latched as a pending
// event. A software mask gates which pending sources are eligible. The
// highest eligible source is presented to the host, which sequences it
// through the handshake request -> acknowledge -> service -> end-of-interrupt.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en_n        active-low global enable; high blocks new interrupts
//   req_n[7:0]  asynchronous active-low request lines
//   mask_we     mask register write strobe
//   mask_wdata  mask value, 1 = source masked
//   ack         host acknowledge pulse
//   eoi         host end-of-interrupt pulse
//   irq         interrupt request to host
//   vector      VEC_BASE + code
//   code        latched winning source index
//   busy        high while a source is in service
//   pending     latched pending events
//   in_service  one-hot source currently in service

module irq_priority_ctrl8 #(
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_n,
  input  logic [7:0] req_n,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [7:0] vector,
  output logic [2:0] code,
  output logic       busy,
  output logic [7:0] pending,
  output logic [7:0] in_service
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] sync1_q, sync2_q, prev_q;
  logic [7:0] mask_q, mask_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] in_service_q, in_service_d;
  logic [2:0] code_q, code_d;
  logic [7:0] vector_q, vector_d;
  logic       irq_q, irq_d;
  logic       busy_q, busy_d;

  logic [7:0] fall;
  logic [7:0] eligible;
  logic [2:0] winner;
  logic [7:0] code_onehot;
  logic [7:0] clr;

  // A 1->0 step of the synchronised line is an event; a held low level is not.
  assign fall     = prev_q & ~sync2_q;
  assign eligible = pending_q & ~mask_q;

  // Later (higher) indices override earlier ones, so bit 7 wins.
  always_comb begin
    winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  assign code_onehot = 8'b1 << code_q;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_we ? mask_wdata : mask_q;
    in_service_d = in_service_q;
    code_d       = code_q;
    vector_d     = vector_q;
    irq_d        = irq_q;
    busy_d       = busy_q;
    clr          = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (!en_n && (eligible != 8'h00)) begin
          state_d  = REQ;
          code_d   = winner;
          vector_d = VEC_BASE + {5'b0, winner};
          irq_d    = 1'b1;
        end
      end
      REQ: begin
        // Code and vector stay frozen here; ack outranks both eoi and en_n.
        if (ack) begin
          clr          = code_onehot;
          in_service_d = code_onehot;
          irq_d        = 1'b0;
          busy_d       = 1'b1;
          state_d      = SERVICE;
        end else if (en_n) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_d = 8'h00;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A new edge arriving with the acknowledge clear is kept: set wins.
    pending_d = (pending_q & ~clr) | fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 8'hFF;
      sync2_q      <= 8'hFF;
      prev_q       <= 8'hFF;
      mask_q       <= 8'h00;
      pending_q    <= 8'h00;
      in_service_q <= 8'h00;
      code_q       <= 3'd0;
      vector_q     <= VEC_BASE;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      state_q      <= IDLE;
    end else begin
      sync1_q      <= req_n;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      code_q       <= code_d;
      vector_q     <= vector_d;
      irq_q        <= irq_d;
      busy_q       <= busy_d;
      state_q      <= state_d;
    end
  end

  assign irq        = irq_q;
  assign vector     = vector_q;
  assign code       = code_q;
  assign busy       = busy_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
